bee_sprite_line: RTL
====================

Name: bee_sprite_line

Overview:
- Per-scanline sprite renderer that sits directly downstream of the VGA timing generator (640x480 @ 60 Hz, 25.2 MHz pixel clock).
- Consumes sx, a line-start pulse and the next line's y coordinate; fetches one bitmap row from an external synchronous sprite ROM during horizontal blanking.
- Emits a 1-bit sprite pixel and a drawing flag, replicated SCALE times horizontally and vertically, for the colour/pixel-mux stage that follows.

Parameters:
- CORDW, 10, screen coordinate width in bits.
- SPR_WIDTH, 8, sprite width in source pixels; equals the ROM word width.
- SPR_HEIGHT, 8, sprite height in source rows.
- SCALE_LOG2, 1, log2 of the integer scale factor (SCALE = 2^SCALE_LOG2, range 0..3).
- ROM_ADDRW, 3, ROM address width; must be ≥ clog2(SPR_HEIGHT).

Ports:
- clk_pix  in  1  pixel clock, 25.2 MHz; all logic on the rising edge.
- rst_pix  in  1  synchronous, active-high reset.
- line  in  1  one-cycle pulse; the next scanline is about to start.
- line_y  in  CORDW  y of the scanline about to be drawn; valid when line=1.
- sx  in  CORDW  current horizontal position from the timing generator.
- sprx  in  CORDW  sprite left x; sampled when line=1.
- spry  in  CORDW  sprite top y; sampled when line=1.
- rom_addr  out  ROM_ADDRW  sprite row address.
- rom_data  in  SPR_WIDTH  ROM row; valid exactly 1 cycle after rom_addr changes; MSB is the leftmost pixel.
- pix  out  1  sprite pixel value, registered.
- drawing  out  1  high while the sprite covers the position, registered.

Behaviour:
- Reset, applied synchronously: state=IDLE, pix=0, drawing=0, rom_addr=0, all counters=0. Reset overrides a coincident line pulse.
- Output latency: pix and drawing at cycle t+1 describe the sx presented at cycle t. The downstream stage delays hsync, vsync and de by 1 cycle to match.
- FSM states: IDLE, FETCH, LOAD, WAIT_POS, DRAW.
- IDLE: pix=0, drawing=0.
  - On line: latch sprx into spr_x_r.
  - Compute dy = line_y − spry as a signed CORDW+1-bit value.
  - If 0 ≤ dy < SPR_HEIGHT<<SCALE_LOG2: set rom_addr = dy>>SCALE_LOG2 and go to FETCH. Otherwise stay in IDLE.
- FETCH: one cycle waiting for ROM latency; go to LOAD.
- LOAD: latch rom_data into shift register; clear bit counter and scale counter; go to WAIT_POS.
- WAIT_POS: when sx == spr_x_r, go to DRAW. The registered outputs for this cycle are drawing=1 and pix=shreg MSB.
- DRAW: every cycle, drawing=1 and pix=shreg MSB.
  - Scale counter counts 0..SCALE−1; on wrap, shift shreg left by 1 and increment the bit counter.
  - After SPR_WIDTH·SCALE pixels, i.e. when the bit counter wraps at SPR_WIDTH, go to IDLE. The next registered outputs are drawing=0, pix=0.
- A line pulse in any non-IDLE state aborts the current row (drawing=0 next cycle) and is evaluated exactly as in IDLE in the same cycle.
- Ordering requirement: line must precede the cycle where sx == sprx by ≥3 cycles. The integration fires line at sx=640, so sprx in 0..639 is safe.
- If sx never equals spr_x_r, the FSM waits in WAIT_POS until the next line pulse or reset.
- Right-edge overrun: the sprite continues into horizontal blanking with no wrap and no clipping. Downstream gates the output with de.
- All y arithmetic is signed, so spry > line_y never matches. No other wrap-around is permitted.

Test Plan:
All cases use CORDW=10, SPR_WIDTH=8, SPR_HEIGHT=8, SCALE_LOG2=1, sprx=100, spry=50, and a ROM model with row0=8'b1000_0001, row7=8'hFF.
- line at sx=640 with line_y=50 → rom_addr=0; drawing=1 for sx 100..115 (16 cycles, output 1 cycle later); pix=1 only at sx 100, 101, 114, 115; drawing=0 from sx 116.
- line_y=65 → rom_addr=7, pix=1 for all 16 pixels. line_y=66 or line_y=49 → FSM stays in IDLE; drawing and pix remain 0 for the whole line.
- sprx=630, line_y=50 → drawing for sx 630..645 (into blanking), pix at sx 630, 631, 644, 645; no wrap to sx=0.
- line pulse injected while sx=106 in DRAW with line_y=50 → drawing=0 the next cycle, a new fetch of rom_addr=0 follows, and the row redraws correctly at the next sx=100.
- rst_pix asserted at sx=104 in DRAW → pix=0, drawing=0, rom_addr=0 the next cycle. rst_pix and line asserted together → reset wins. A line after release renders normally.

Source files
------------

// File: rtl/bee_sprite_line.sv
// rtl/bee_sprite_line.sv - per-scanline scaled sprite renderer fed by a synchronous sprite ROM
//
// Purpose:
//   On each line pulse, decide whether the upcoming scanline crosses the
//   sprite. If it does, fetch the matching bitmap row from an external
//   synchronous ROM during horizontal blanking. Then replay that row at
//   sx == sprx, with each source pixel widened SCALE times. Rows are
//   repeated SCALE times vertically because the ROM row is chosen from
//   (line_y - spry) >> SCALE_LOG2.
//
// Ports:
//   clk_pix   in   1          pixel clock, all logic on rising edge
//   rst_pix   in   1          synchronous active-high reset
//   line      in   1          one-cycle pulse, next scanline about to start
//   line_y    in   CORDW      y of the next scanline (valid with line)
//   sx        in   CORDW      current horizontal position
//   sprx      in   CORDW      sprite left x (sampled with line)
//   spry      in   CORDW      sprite top y (sampled with line)
//   rom_addr  out  ROM_ADDRW  sprite row address
//   rom_data  in   SPR_WIDTH  ROM row, one cycle after rom_addr, MSB leftmost
//   pix       out  1          registered sprite pixel
//   drawing   out  1          registered sprite-coverage flag
//
// pix/drawing at cycle t+1 describe the sx presented at cycle t.

module bee_sprite_line #(
  parameter int CORDW      = 10,
  parameter int SPR_WIDTH  = 8,
  parameter int SPR_HEIGHT = 8,
  parameter int SCALE_LOG2 = 1,
  parameter int ROM_ADDRW  = 3
) (
  input  logic                 clk_pix,
  input  logic                 rst_pix,
  input  logic                 line,
  input  logic [CORDW-1:0]     line_y,
  input  logic [CORDW-1:0]     sx,
  input  logic [CORDW-1:0]     sprx,
  input  logic [CORDW-1:0]     spry,
  output logic [ROM_ADDRW-1:0] rom_addr,
  input  logic [SPR_WIDTH-1:0] rom_data,
  output logic                 pix,
  output logic                 drawing
);

  localparam int SCALE       = 1 << SCALE_LOG2;
  localparam int SCW         = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam int BCW         = (SPR_WIDTH > 1) ? $clog2(SPR_WIDTH) : 1;
  localparam int ROWS_SCALED = SPR_HEIGHT << SCALE_LOG2;

  localparam logic signed [CORDW:0] ROWS_LIM  = ROWS_SCALED[CORDW:0];
  localparam logic [SCW-1:0]        SCALE_MAX = SCW'(SCALE - 1);
  localparam logic [BCW-1:0]        BIT_MAX   = BCW'(SPR_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    WAIT_POS,
    DRAW
  } state_t;

  state_t                state, state_d;
  logic [CORDW-1:0]      spr_x_r, spr_x_d;
  logic [SPR_WIDTH-1:0]  shreg, shreg_d;
  logic [BCW-1:0]        bit_cnt, bit_cnt_d;
  logic [SCW-1:0]        scale_cnt, scale_cnt_d;
  logic [ROM_ADDRW-1:0]  rom_addr_d;
  logic                  pix_d, drawing_d;
  logic                  emit;

  // One extra bit keeps the subtraction signed, so a sprite that starts
  // below the current line yields a negative dy and never matches.
  logic signed [CORDW:0] dy;
  logic                  row_hit;

  assign dy      = $signed({1'b0, line_y}) - $signed({1'b0, spry});
  assign row_hit = !dy[CORDW] && (dy < ROWS_LIM);

  always_comb begin
    state_d     = state;
    spr_x_d     = spr_x_r;
    shreg_d     = shreg;
    bit_cnt_d   = bit_cnt;
    scale_cnt_d = scale_cnt;
    rom_addr_d  = rom_addr;
    pix_d       = 1'b0;
    drawing_d   = 1'b0;
    emit        = 1'b0;

    if (line) begin
      // A line pulse restarts the row from any state.
      spr_x_d = sprx;
      if (row_hit) begin
        rom_addr_d = ROM_ADDRW'(dy >> SCALE_LOG2);
        state_d    = FETCH;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state)
        IDLE: begin
          state_d = IDLE;
        end
        FETCH: begin
          // ROM data for the new address shows up next cycle.
          state_d = LOAD;
        end
        LOAD: begin
          shreg_d     = rom_data;
          bit_cnt_d   = '0;
          scale_cnt_d = '0;
          state_d     = WAIT_POS;
        end
        WAIT_POS: begin
          // The matching cycle already produces the first output pixel.
          if (sx == spr_x_r) begin
            state_d = DRAW;
            emit    = 1'b1;
          end
        end
        DRAW: begin
          emit = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (emit) begin
      drawing_d = 1'b1;
      pix_d     = shreg[SPR_WIDTH-1];
      if (scale_cnt == SCALE_MAX) begin
        scale_cnt_d = '0;
        shreg_d     = shreg << 1;
        bit_cnt_d   = bit_cnt + BCW'(1);
        if (bit_cnt == BIT_MAX) begin
          state_d = IDLE;
        end
      end else begin
        scale_cnt_d = scale_cnt + SCW'(1);
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state     <= IDLE;
      spr_x_r   <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      scale_cnt <= '0;
      rom_addr  <= '0;
      pix       <= 1'b0;
      drawing   <= 1'b0;
    end else begin
      state     <= state_d;
      spr_x_r   <= spr_x_d;
      shreg     <= shreg_d;
      bit_cnt   <= bit_cnt_d;
      scale_cnt <= scale_cnt_d;
      rom_addr  <= rom_addr_d;
      pix       <= pix_d;
      drawing   <= drawing_d;
    end
  end

endmodule
